ps2_mouse_ctrl: RTL

Sequencer that sits between the system and the PS2 transceiver core.
It resets the mouse, checks its self-test responses and enables stream mode. It then assembles incoming 3-byte movement packets into signed deltas and button state.
It owns the core's Write/TxData handshake exclusively and recovers from timeouts, resend requests and packet desynchronisation without host intervention.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_mouse_ctrl_if.sv | 12 +
 rtl/ps2_packet_asm.sv | 72 +++++++
 rtl/ps2_mouse_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared command/response codes, FSM states and the decoded packet type
// for the PS/2 mouse controller.
package ps2_pkg;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ID_MOUSE = 8'h00;

  typedef enum logic [3:0] {
    S_RST_TX, S_RST_WTX, S_RST_ACK, S_BAT, S_ID,
    S_EN_TX, S_EN_WTX, S_EN_ACK, S_STREAM, S_ERR
  } state_e;

  typedef struct packed {
    logic [2:0] buttons;
    logic [8:0] dx;
    logic [8:0] dy;
  } pkt_t;
endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// Write/TxData/TxDone/RxDone/RxData handshake between the controller
// (master) and the PS/2 transceiver core (slave).
interface ps2_mouse_ctrl_if;
  logic       Write;
  logic [7:0] TxData;
  logic       TxDone;
  logic       RxDone;
  logic [7:0] RxData;

  modport master (output Write, TxData, input TxDone, RxDone, RxData);
  modport slave  (input Write, TxData, output TxDone, RxDone, RxData);
endinterface

// File: rtl/ps2_packet_asm.sv
// Stream-mode packet assembler: byte index, inter-byte gap watchdog,
// bit3 resync and overflow-clamped delta decode.
module ps2_packet_asm
  import ps2_pkg::*;
#(
  parameter int unsigned BYTE_GAP_CYC = 1_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       en,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       pkt_valid,
  output pkt_t       pkt
);
  localparam int GW = $clog2(BYTE_GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(BYTE_GAP_CYC);

  logic [1:0]    idx_q;
  logic [6:0]    hdr_q;  // byte0 minus its always-one bit3: {ovf_y, ovf_x, sgn_y, sgn_x, buttons}
  logic [7:0]    b1_q;
  logic [GW-1:0] gap_q;

  function automatic logic [8:0] clamp(input logic ovf, input logic sgn, input logic [7:0] mag);
    if (ovf) return sgn ? 9'h100 : 9'h0FF;
    return {sgn, mag};
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx_q     <= '0;
      hdr_q     <= '0;
      b1_q      <= '0;
      gap_q     <= '0;
      pkt_valid <= 1'b0;
      pkt       <= '0;
    end else begin
      pkt_valid <= 1'b0;
      if (!en) begin
        idx_q <= '0;
        gap_q <= '0;
      end else if (rx_done) begin
        gap_q <= '0;
        unique case (idx_q)
          2'd0: if (rx_data[3]) begin
            hdr_q <= {rx_data[7:4], rx_data[2:0]};
            idx_q <= 2'd1;
          end
          2'd1: begin
            b1_q  <= rx_data;
            idx_q <= 2'd2;
          end
          default: begin
            pkt_valid <= 1'b1;
            pkt <= '{buttons: hdr_q[2:0],
                     dx: clamp(hdr_q[5], hdr_q[3], b1_q),
                     dy: clamp(hdr_q[6], hdr_q[4], rx_data)};
            idx_q <= 2'd0;
          end
        endcase
      end else if (idx_q != 2'd0) begin
        // a stalled packet is abandoned so the next header realigns the stream
        if (gap_q == GAP_MAX) begin
          idx_q <= '0;
          gap_q <= '0;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse init sequencer (reset, self-test, enable) with timeout/retry
// recovery, handing off to the packet assembler in stream mode.
module ps2_mouse_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 50_000_000,
  parameter int unsigned BYTE_GAP_CYC = 1_000_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  ps2_mouse_ctrl_if.master        ps2,
  output logic                    Ready,
  output logic                    Error,
  output logic                    PktValid,
  output logic [2:0]              Buttons,
  output logic [8:0]              DX,
  output logic [8:0]              DY
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e        state_q, state_nx;
  logic          wr_q, wr_nx;
  logic [7:0]    txd_q, txd_nx;
  logic [RW-1:0] retry_q, retry_nx;
  logic [TW-1:0] tcnt_q;
  logic          tmo, fail;
  pkt_t          pkt;

  assign tmo        = (tcnt_q == TMO_LAST);
  assign ps2.Write  = wr_q;
  assign ps2.TxData = txd_q;
  assign Ready      = (state_q == S_STREAM);
  assign Error      = (state_q == S_ERR);

  always_comb begin
    state_nx = state_q;
    wr_nx    = 1'b0;
    txd_nx   = txd_q;
    retry_nx = retry_q;
    fail     = 1'b0;
    unique case (state_q)
      S_RST_TX: begin wr_nx = 1'b1; txd_nx = CMD_RESET;  state_nx = S_RST_WTX; end
      S_EN_TX:  begin wr_nx = 1'b1; txd_nx = CMD_ENABLE; state_nx = S_EN_WTX;  end
      S_RST_WTX: if (ps2.TxDone) state_nx = S_RST_ACK; else fail = tmo;
      S_EN_WTX:  if (ps2.TxDone) state_nx = S_EN_ACK;  else fail = tmo;
      S_RST_ACK, S_EN_ACK: begin
        if (ps2.RxDone) begin
          if (ps2.RxData == RSP_ACK)         state_nx = (state_q == S_RST_ACK) ? S_BAT : S_STREAM;
          else if (ps2.RxData == RSP_RESEND) state_nx = (state_q == S_RST_ACK) ? S_RST_TX : S_EN_TX;
          else                               fail = 1'b1;
        end else fail = tmo;
      end
      S_BAT: if (ps2.RxDone) begin
        if (ps2.RxData == RSP_BAT_OK) state_nx = S_ID; else fail = 1'b1;
      end else fail = tmo;
      S_ID: if (ps2.RxDone) begin
        if (ps2.RxData == RSP_ID_MOUSE) state_nx = S_EN_TX; else fail = 1'b1;
      end else fail = tmo;
      default: ;
    endcase
    if (fail) begin
      if (retry_q == RETRY_MAX) state_nx = S_ERR;
      else begin
        retry_nx = retry_q + 1'b1;
        state_nx = S_RST_TX;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_RST_TX;
      wr_q    <= 1'b0;
      txd_q   <= '0;
      retry_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_nx;
      wr_q    <= wr_nx;
      txd_q   <= txd_nx;
      retry_q <= retry_nx;
      if (state_nx != state_q) tcnt_q <= '0;
      else if (!tmo)           tcnt_q <= tcnt_q + 1'b1;
    end
  end

  ps2_packet_asm #(.BYTE_GAP_CYC(BYTE_GAP_CYC)) u_asm (
    .Clk       (Clk),
    .Reset     (Reset),
    .en        (state_q == S_STREAM),
    .rx_done   (ps2.RxDone),
    .rx_data   (ps2.RxData),
    .pkt_valid (PktValid),
    .pkt       (pkt)
  );

  assign Buttons = pkt.buttons;
  assign DX      = pkt.dx;
  assign DY      = pkt.dy;
endmodule
